// File: rtl/cdma_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : cdma_rd_sched
// Purpose  : Round-robin command scheduler that shares one CDMA read engine
//            among N_REQ requesters. It stages one command toward the
//            engine, records the grant order in an ID FIFO, routes engine
//            completions back to their owners and exports the owner of the
//            oldest in-flight transfer for downstream stream steering.
// Ports    : aclk/aresetn            - clock, async active-low reset
//            req_valid/ready/paddr/len - per-requester command interface
//            req_done / req_err       - completion pulse / sticky illegal-len
//            rd_valid/ready/paddr/len - staged command toward the engine
//            rd_done                  - engine completion (in command order)
//            head_id / head_valid     - owner of oldest outstanding command
//            outst_cnt                - ID FIFO occupancy
//            spur_done                - sticky: rd_done with nothing pending
// Revision : 1.0 - initial release
// ============================================================================
module cdma_rd_sched #(
    parameter int N_REQ     = 4,
    parameter int ADDR_BITS = 64,
    parameter int LEN_BITS  = 32,
    parameter int MAX_OUTST = 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*ADDR_BITS-1:0]     req_paddr,
    input  logic [N_REQ*LEN_BITS-1:0]      req_len,
    output logic [N_REQ-1:0]               req_done,
    output logic [N_REQ-1:0]               req_err,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [ADDR_BITS-1:0]           rd_paddr,
    output logic [LEN_BITS-1:0]            rd_len,
    input  logic                           rd_done,
    output logic [$clog2(N_REQ)-1:0]       head_id,
    output logic                           head_valid,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic                           spur_done
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = $clog2(MAX_OUTST+1);
    // The engine only honours length bits [22:0]
    localparam int LEN_LEGAL_BITS = 23;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ID_W-1:0]      ptr_q,      ptr_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0] rd_paddr_q, rd_paddr_d;
    logic [LEN_BITS-1:0]  rd_len_q,   rd_len_d;
    logic [PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [ID_W-1:0]      head_id_q,  head_id_d;
    logic                 head_vld_q, head_vld_d;
    logic [N_REQ-1:0]     done_q,     done_d;
    logic [N_REQ-1:0]     err_q,      err_d;
    logic                 spur_q,     spur_d;
    logic [ID_W-1:0]      fifo_q [MAX_OUTST];

    // ------------------------------------------------------------------
    // Round-robin arbitration starting at ptr_q
    // ------------------------------------------------------------------
    logic                 w_win_vld;
    logic [ID_W-1:0]      w_win_id;
    logic [ADDR_BITS-1:0] w_win_addr;
    logic [LEN_BITS-1:0]  w_win_len;
    logic                 w_win_legal;
    logic                 w_slot_free;
    logic                 w_fifo_full;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic [N_REQ-1:0]     w_ready;

    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_win_vld && req_valid[idx]) begin
                w_win_vld = 1'b1;
                w_win_id  = ID_W'(idx);
            end
        end
    end

    assign w_win_addr  = req_paddr[int'(w_win_id)*ADDR_BITS +: ADDR_BITS];
    assign w_win_len   = req_len[int'(w_win_id)*LEN_BITS +: LEN_BITS];
    assign w_win_legal = (w_win_len != '0) &&
                         (w_win_len[LEN_BITS-1:LEN_LEGAL_BITS] == '0);

    assign w_slot_free = !rd_valid_q || rd_ready;
    assign w_fifo_full = (cnt_q == CNT_W'(MAX_OUTST));

    // Illegal commands are swallowed without touching the stage or FIFO,
    // so they never wait on backpressure.
    assign w_accept = w_win_vld &&
                      (!w_win_legal || (w_slot_free && !w_fifo_full));
    assign w_push   = w_accept && w_win_legal;
    assign w_pop    = rd_done && (cnt_q != '0);

    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_win_id] = 1'b1;
        end
    end

    // Combinational ready is forced low while reset is asserted
    assign req_ready = w_ready & {N_REQ{aresetn}};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d      = ptr_q;
        rd_valid_d = rd_valid_q;
        rd_paddr_d = rd_paddr_q;
        rd_len_d   = rd_len_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        spur_d     = spur_q;
        done_d     = '0;

        if (w_accept) begin
            ptr_d = (int'(w_win_id) == N_REQ-1) ? '0 : w_win_id + ID_W'(1);
            if (!w_win_legal) begin
                err_d[w_win_id] = 1'b1;
            end
        end

        // Stage: load on push, otherwise drain on handshake
        if (w_push) begin
            rd_valid_d = 1'b1;
            rd_paddr_d = w_win_addr;
            rd_len_d   = w_win_len;
        end else if (rd_ready) begin
            rd_valid_d = 1'b0;
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
            done_d[head_id_q] = 1'b1;
        end
        if (rd_done && (cnt_q == '0)) begin
            spur_d = 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // Next head: if the entry being pushed lands exactly at the new
        // read pointer, it is not in fifo_q yet, so forward it directly.
        head_vld_d = (cnt_d != '0);
        if (cnt_d == '0) begin
            head_id_d = '0;
        end else if (w_push && (wr_ptr_q == rd_ptr_d)) begin
            head_id_d = w_win_id;
        end else begin
            head_id_d = fifo_q[rd_ptr_d];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_paddr_q <= '0;
            rd_len_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            head_id_q  <= '0;
            head_vld_q <= 1'b0;
            done_q     <= '0;
            err_q      <= '0;
            spur_q     <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_paddr_q <= rd_paddr_d;
            rd_len_q   <= rd_len_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            head_id_q  <= head_id_d;
            head_vld_q <= head_vld_d;
            done_q     <= done_d;
            err_q      <= err_d;
            spur_q     <= spur_d;
        end
    end

    // ID storage needs no reset: entries are only read when counted valid
    always_ff @(posedge aclk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= w_win_id;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_paddr   = rd_paddr_q;
    assign rd_len     = rd_len_q;
    assign head_id    = head_id_q;
    assign head_valid = head_vld_q;
    assign outst_cnt  = cnt_q;
    assign req_done   = done_q;
    assign req_err    = err_q;
    assign spur_done  = spur_q;

endmodule
`default_nettype wire

// File: tb/tb_cdma_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdma_rd_sched
// Purpose  : Self-checking bench for cdma_rd_sched. A queue-based model of
//            the scheduler is compared against the DUT every cycle, and
//            directed scenarios add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdma_rd_sched;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int LW = 32;
    localparam int MO = 8;

    logic            aclk;
    logic            aresetn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_paddr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    req_done;
    logic [N-1:0]    req_err;
    logic            rd_valid;
    logic            rd_ready;
    logic [AW-1:0]   rd_paddr;
    logic [LW-1:0]   rd_len;
    logic            rd_done;
    logic [1:0]      head_id;
    logic            head_valid;
    logic [3:0]      outst_cnt;
    logic            spur_done;

    int checks = 0;
    int errors = 0;

    cdma_rd_sched #(.N_REQ(N), .ADDR_BITS(AW), .LEN_BITS(LW), .MAX_OUTST(MO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_paddr(req_paddr), .req_len(req_len),
        .req_done(req_done), .req_err(req_err),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_paddr(rd_paddr), .rd_len(rd_len),
        .rd_done(rd_done),
        .head_id(head_id), .head_valid(head_valid),
        .outst_cnt(outst_cnt), .spur_done(spur_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int           m_ptr;
    int           m_q[$];
    bit           m_sv;
    logic [63:0]  m_addr;
    logic [31:0]  m_len;
    logic [N-1:0] m_done;
    logic [N-1:0] m_err;
    bit           m_spur;

    function automatic int winner(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic bit is_legal(input logic [31:0] l);
        return (l != 0) && (l < 32'h0080_0000);
    endfunction

    function automatic bit model_accepts(input int w);
        if (w < 0) return 1'b0;
        if (!is_legal(req_len[w*LW +: LW])) return 1'b1;
        return (!m_sv || rd_ready) && (m_q.size() < MO);
    endfunction

    initial begin
        m_ptr = 0; m_sv = 0; m_addr = '0; m_len = '0;
        m_done = '0; m_err = '0; m_spur = 0;
        forever begin
            @(posedge aclk or negedge aresetn);
            if (!aresetn) begin
                m_ptr = 0; m_q.delete(); m_sv = 0; m_addr = '0; m_len = '0;
                m_done = '0; m_err = '0; m_spur = 0;
            end else begin
                int w;
                bit acc;
                bit lg;
                logic [N-1:0] nd;
                w   = winner(m_ptr, req_valid);
                acc = model_accepts(w);
                lg  = (w >= 0) ? is_legal(req_len[w*LW +: LW]) : 1'b0;
                nd  = '0;
                if (rd_done) begin
                    if (m_q.size() > 0) nd[m_q.pop_front()] = 1'b1;
                    else m_spur = 1;
                end
                if (acc && lg) begin
                    m_q.push_back(w);
                    m_sv   = 1;
                    m_addr = req_paddr[w*AW +: AW];
                    m_len  = req_len[w*LW +: LW];
                end else if (rd_ready) begin
                    m_sv = 0;
                end
                if (acc) begin
                    m_ptr = (w + 1) % N;
                    if (!lg) m_err[w] = 1'b1;
                end
                m_done = nd;
            end
        end
    end

    // Per-cycle comparison, mid-cycle on the falling edge
    initial begin
        forever begin
            logic [N-1:0] er;
            int w;
            @(negedge aclk);
            er = '0;
            w  = winner(m_ptr, req_valid);
            if (aresetn && model_accepts(w)) er[w] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("rd_valid", 64'(rd_valid), 64'(m_sv));
            if (m_sv) begin
                chk("rd_paddr", rd_paddr, m_addr);
                chk("rd_len", 64'(rd_len), 64'(m_len));
            end
            chk("req_done", 64'(req_done), 64'(m_done));
            chk("req_err", 64'(req_err), 64'(m_err));
            chk("spur_done", 64'(spur_done), 64'(m_spur));
            chk("outst_cnt", 64'(outst_cnt), 64'(m_q.size()));
            chk("head_valid", 64'(head_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0) chk("head_id", 64'(head_id), 64'(m_q[0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic [63:0] a, input logic [31:0] l);
        req_paddr[i*AW +: AW] = a;
        req_len[i*LW +: LW]   = l;
    endtask

    task automatic count_acc(input int n, output int acc);
        acc = 0;
        repeat (n) begin
            #1;
            if (req_ready != '0) acc++;
            tick();
        end
    endtask

    initial begin
        int acc;
        logic [N-1:0] exp_g;
        aresetn   = 1'b1;
        req_valid = '0;
        req_paddr = '0;
        req_len   = '0;
        rd_ready  = 1'b0;
        rd_done   = 1'b0;
        #3 aresetn = 1'b0;
        tick();
        tick();
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_outst", 64'(outst_cnt), 64'd0);
        aresetn = 1'b1;
        tick();

        // Single command
        set_cmd(0, 64'h1000, 32'd256);
        req_valid = 4'b0001;
        rd_ready  = 1'b1;
        #1 chk("single_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        chk("single_rd_valid", 64'(rd_valid), 64'd1);
        chk("single_paddr", rd_paddr, 64'h1000);
        chk("single_len", 64'(rd_len), 64'd256);
        chk("single_outst", 64'(outst_cnt), 64'd1);
        repeat (9) tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("single_done", 64'(req_done), 64'h1);
        chk("single_outst0", 64'(outst_cnt), 64'd0);
        tick();

        // Fairness: pointer sits at 1 after the single command
        for (int i = 0; i < N; i++) set_cmd(i, 64'h2000 + 64'(i) * 64'h100, 32'd16 + 32'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_g = 4'b0001 << ((1 + k) % N);
            chk("fair_grant", 64'(req_ready), 64'(exp_g));
            tick();
        end
        req_valid = '0;
        chk("fair_full", 64'(outst_cnt), 64'd8);
        rd_done = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_g = 4'b0001 << ((1 + k) % N);
            chk("fair_done", 64'(req_done), 64'(exp_g));
        end
        rd_done = 1'b0;
        tick();

        // Backpressure and full
        rd_ready  = 1'b0;
        req_valid = 4'b1111;
        count_acc(20, acc);
        chk("stall_accepts", 64'(acc), 64'd1);
        chk("stall_paddr", rd_paddr, 64'h2100);
        rd_ready = 1'b1;
        count_acc(12, acc);
        chk("release_accepts", 64'(acc), 64'd7);
        chk("full_outst", 64'(outst_cnt), 64'd8);
        #1 chk("full_ready", 64'(req_ready), 64'd0);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        count_acc(5, acc);
        chk("one_more_accept", 64'(acc), 64'd1);
        req_valid = '0;
        rd_done   = 1'b1;
        repeat (8) tick();
        rd_done = 1'b0;
        tick();

        // Illegal lengths from a fresh pointer
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        set_cmd(2, 64'h3000, 32'd0);
        req_valid = 4'b0100;
        #1 chk("illegal0_ready", 64'(req_ready), 64'h4);
        tick();
        set_cmd(2, 64'h3000, 32'h0080_0000);
        #1 chk("illegal1_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        chk("illegal_err", 64'(req_err), 64'h4);
        chk("illegal_rd_valid", 64'(rd_valid), 64'd0);
        chk("illegal_outst", 64'(outst_cnt), 64'd0);
        req_valid = 4'b1111;
        #1 chk("illegal_ptr3", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;

        // Simultaneous push/pop, then spurious done
        req_valid = 4'b0001;
        repeat (2) tick();
        chk("pp_outst3", 64'(outst_cnt), 64'd3);
        rd_done = 1'b1;
        tick();
        chk("pp_same", 64'(outst_cnt), 64'd3);
        req_valid = '0;
        repeat (3) tick();
        chk("drain_outst", 64'(outst_cnt), 64'd0);
        tick();
        rd_done = 1'b0;
        chk("spur_set", 64'(spur_done), 64'd1);
        chk("spur_no_done", 64'(req_done), 64'd0);
        tick();

        // Asynchronous reset mid-burst
        set_cmd(2, 64'h3000, 32'd64);
        req_valid = 4'b1111;
        repeat (5) tick();
        chk("burst_outst", 64'(outst_cnt), 64'd5);
        chk("burst_rd_valid", 64'(rd_valid), 64'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_rd_valid", 64'(rd_valid), 64'd0);
        chk("arst_outst", 64'(outst_cnt), 64'd0);
        chk("arst_ready", 64'(req_ready), 64'd0);
        chk("arst_err", 64'(req_err), 64'd0);
        chk("arst_spur", 64'(spur_done), 64'd0);
        chk("arst_head", 64'(head_valid), 64'd0);
        tick();
        req_valid = '0;
        tick();
        aresetn = 1'b1;
        tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("post_rst_spur", 64'(spur_done), 64'd1);
        chk("post_rst_no_done", 64'(req_done), 64'd0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
